// File: rtl/fetch_unit.sv
// Instruction fetch stage for the SISC processor.
// Holds the program counter, fetches instruction words over a variable-latency
// request/acknowledge handshake, loads the instruction register that feeds the
// datapath, applies branch targets, and aborts stalled fetches with a watchdog.
module fetch_unit #(
  parameter int unsigned PC_WIDTH = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic                fetch_start,
  input  logic                br_load,
  input  logic                br_sel,
  input  logic [PC_WIDTH-1:0] br_imm,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic [31:0]         ir,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_done,
  output logic                fetch_err,
  output logic                busy
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_RST  = PC_WIDTH'(RESET_PC);
  localparam logic [7:0]          WD_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic                  pend_q, pend_d;
  logic [PC_WIDTH-1:0]   tgt_q, tgt_d;
  logic [7:0]            wd_q, wd_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [PC_WIDTH-1:0]   br_tgt;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   next_pc;

  // Branch target and post-fetch PC selection (all arithmetic wraps mod 2^PC_WIDTH).
  // A br_load on the completing edge wins over an older pending target.
  always_comb begin
    br_tgt  = br_sel ? br_imm : (pc_q + br_imm);
    pc_inc  = pc_q + PC_WIDTH'(1);
    next_pc = pc_inc;
    if (br_load) begin
      next_pc = br_tgt;
    end else if (pend_q) begin
      next_pc = tgt_q;
    end
  end

  // Next-state logic for the IDLE/REQ fetch controller and its datapath registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (br_load) begin
          pc_d = br_tgt;
        end
        if (fetch_start) begin
          state_d = REQ;
          wd_d    = '0;
        end
      end
      REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = next_pc;
          pend_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          ir_d    = '0;
          pc_d    = next_pc;
          pend_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
          if (br_load) begin
            pend_d = 1'b1;
            tgt_d  = br_tgt;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      ir_q    <= '0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Request and busy decode straight from state so reset drops them immediately.
  always_comb begin
    imem_req   = (state_q == REQ);
    busy       = (state_q == REQ);
    imem_addr  = pc_q;
    pc         = pc_q;
    ir         = ir_q;
    fetch_done = done_q;
    fetch_err  = err_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetches push expected results,
// a monitor pops and compares on every fetch_done/fetch_err pulse.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        fetch_start;
  logic        br_load;
  logic        br_sel;
  logic [15:0] br_imm;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] ir;
  logic [15:0] pc;
  logic        fetch_done;
  logic        fetch_err;
  logic        busy;

  typedef struct {
    logic        err;
    logic [31:0] ir;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   ack_lat   = 1;
  bit   no_ack    = 1'b0;
  bit   force_ack = 1'b0;
  int   req_cnt   = 0;

  fetch_unit #(
    .PC_WIDTH(16),
    .RESET_PC(0),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .fetch_start(fetch_start),
    .br_load    (br_load),
    .br_sel     (br_sel),
    .br_imm     (br_imm),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .ir         (ir),
    .pc         (pc),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: word at address a is 0x11000000 + a + 1; ack in REQ cycle ack_lat.
  always @(negedge clk) begin
    imem_rdata = 32'h1100_0000 + {16'h0, imem_addr} + 32'd1;
    if (force_ack) begin
      imem_ack = 1'b1;
    end else if (imem_req) begin
      req_cnt++;
      imem_ack = !no_ack && (req_cnt == ack_lat);
    end else begin
      req_cnt  = 0;
      imem_ack = 1'b0;
    end
  end

  // Monitor: every completion pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_f && (fetch_done || fetch_err)) begin
      check("done_err_exclusive", {63'h0, fetch_done & fetch_err}, 64'h0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_completion: got done=%0b err=%0b expected none", fetch_done, fetch_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cmpl_err_flag", {63'h0, fetch_err}, {63'h0, e.err});
        check("cmpl_ir", {32'h0, ir}, {32'h0, e.ir});
        check("cmpl_pc", {48'h0, pc}, {48'h0, e.pc});
      end
    end
  end

  task automatic br_idle(input logic sel, input logic [15:0] imm, input logic [15:0] exp_pc);
    br_load = 1'b1;
    br_sel  = sel;
    br_imm  = imm;
    @(negedge clk);
    br_load = 1'b0;
    check("br_idle_pc", {48'h0, pc}, {48'h0, exp_pc});
  endtask

  task automatic do_fetch(input logic [15:0] exp_addr, input logic [31:0] exp_ir,
                          input logic [15:0] exp_pc, input logic exp_err, input int exp_req,
                          input bit start_br, input logic [15:0] start_imm,
                          input int br1_at, input logic [15:0] br1_imm,
                          input int br2_at, input logic [15:0] br2_imm);
    exp_t e;
    int   req_cycles;
    bit   addr_ok;
    bit   finished;
    e.err = exp_err;
    e.ir  = exp_ir;
    e.pc  = exp_pc;
    sb.push_back(e);
    fetch_start = 1'b1;
    if (start_br) begin
      br_load = 1'b1;
      br_sel  = 1'b1;
      br_imm  = start_imm;
    end
    @(negedge clk);
    fetch_start = 1'b0;
    br_load     = 1'b0;
    req_cycles  = 0;
    addr_ok     = 1'b1;
    finished    = 1'b0;
    for (int i = 0; i < 64 && !finished; i++) begin
      if (imem_req) begin
        req_cycles++;
        if (imem_addr !== exp_addr || busy !== 1'b1) addr_ok = 1'b0;
        if (req_cycles == br1_at) begin
          br_load = 1'b1; br_sel = 1'b1; br_imm = br1_imm;
        end else if (req_cycles == br2_at) begin
          br_load = 1'b1; br_sel = 1'b1; br_imm = br2_imm;
        end
      end
      @(negedge clk);
      br_load = 1'b0;
      if (fetch_done || fetch_err) finished = 1'b1;
    end
    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fetch_wait: got no completion expected one within 64 cycles");
    end
    check("req_cycles", 64'(req_cycles), 64'(exp_req));
    check("req_addr_busy_stable", {63'h0, addr_ok}, 64'h1);
  endtask

  initial begin
    rst_f       = 1'b0;
    fetch_start = 1'b0;
    br_load     = 1'b0;
    br_sel      = 1'b0;
    br_imm      = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", {48'h0, pc}, 64'h0);
    check("rst_ir", {32'h0, ir}, 64'h0);
    check("rst_outs", {60'h0, imem_req, busy, fetch_done, fetch_err}, 64'h0);
    rst_f = 1'b1;
    @(negedge clk);

    // Three back-to-back fetches, ack latency 1.
    ack_lat = 1;
    do_fetch(16'h0000, 32'h1100_0001, 16'h0001, 1'b0, 1, 1'b0, 16'h0, 0, 16'h0, 0, 16'h0);
    do_fetch(16'h0001, 32'h1100_0002, 16'h0002, 1'b0, 1, 1'b0, 16'h0, 0, 16'h0, 0, 16'h0);
    do_fetch(16'h0002, 32'h1100_0003, 16'h0003, 1'b0, 1, 1'b0, 16'h0, 0, 16'h0, 0, 16'h0);

    // Ack after 4 REQ cycles.
    ack_lat = 4;
    do_fetch(16'h0003, 32'h1100_0004, 16'h0004, 1'b0, 4, 1'b0, 16'h0, 0, 16'h0, 0, 16'h0);
    @(negedge clk);

    // Relative branch with negative offset in IDLE, then fetch from the target.
    br_idle(1'b1, 16'h0010, 16'h0010);
    br_idle(1'b0, 16'hFFFE, 16'h000E);
    ack_lat = 1;
    do_fetch(16'h000E, 32'h1100_000F, 16'h000F, 1'b0, 1, 1'b0, 16'h0, 0, 16'h0, 0, 16'h0);
    @(negedge clk);

    // Branches during REQ: second overwrites first, both override increment.
    br_idle(1'b1, 16'h0005, 16'h0005);
    ack_lat = 4;
    do_fetch(16'h0005, 32'h1100_0006, 16'h0040, 1'b0, 4, 1'b0, 16'h0, 1, 16'h0030, 2, 16'h0040);
    @(negedge clk);

    // PC wrap at all-ones.
    br_idle(1'b1, 16'hFFFF, 16'hFFFF);
    ack_lat = 1;
    do_fetch(16'hFFFF, 32'h1101_0000, 16'h0000, 1'b0, 1, 1'b0, 16'h0, 0, 16'h0, 0, 16'h0);
    @(negedge clk);

    // fetch_start together with br_load: fetch uses the new target.
    do_fetch(16'h0020, 32'h1100_0021, 16'h0021, 1'b0, 1, 1'b1, 16'h0020, 0, 16'h0, 0, 16'h0);
    @(negedge clk);

    // Reset in the middle of a REQ; late ack afterwards is ignored.
    no_ack      = 1'b1;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    repeat (2) @(negedge clk);
    check("midreq_req_high", {63'h0, imem_req}, 64'h1);
    #2 rst_f = 1'b0;
    #1;
    check("midreq_rst_req", {62'h0, imem_req, busy}, 64'h0);
    check("midreq_rst_pc", {48'h0, pc}, 64'h0);
    check("midreq_rst_ir", {32'h0, ir}, 64'h0);
    repeat (2) @(negedge clk);
    rst_f     = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_pc", {48'h0, pc}, 64'h0);
    check("late_ack_ir", {32'h0, ir}, 64'h0);
    check("late_ack_idle", {63'h0, busy}, 64'h0);

    // Watchdog abort after 15 REQ cycles.
    do_fetch(16'h0000, 32'h0, 16'h0001, 1'b1, 15, 1'b0, 16'h0, 0, 16'h0, 0, 16'h0);
    @(negedge clk);
    check("wd_idle_after", {62'h0, busy, imem_req}, 64'h0);

    // Ack while IDLE is ignored.
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_pc", {48'h0, pc}, 64'h1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the SISC processor. It sits directly upstream of the `sisc` datapath: it holds the program counter, fetches 32-bit instruction words from an instruction memory with a variable-latency request/acknowledge handshake, and drives the instruction register that feeds the datapath's `ir` input. It also applies branch targets from the control unit and aborts stalled fetches with a watchdog.

## Interface

- `PC_WIDTH`, 16, program counter and instruction-memory address width (word addressed)
- `RESET_PC`, 0, PC value loaded on reset
- `TIMEOUT`, 15, maximum cycles to wait for `imem_ack` before aborting a fetch (1..255)

- `clk`  in  1  clock; all state changes on the rising edge
- `rst_f`  in  1  asynchronous, active-low reset
- `fetch_start`  in  1  control unit requests the next instruction; sampled only in IDLE
- `br_load`  in  1  single-cycle pulse: load a branch target
- `br_sel`  in  1  0 = relative (pc + br_imm), 1 = absolute (br_imm)
- `br_imm`  in  PC_WIDTH  branch offset (two's complement) or absolute target
- `imem_addr`  out  PC_WIDTH  fetch address; equals `pc` while `imem_req` is high
- `imem_req`  out  1  fetch request to instruction memory
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` is high
- `imem_ack`  in  1  memory acknowledge; honoured only while `imem_req` is high
- `ir`  out  32  instruction register, to `sisc.ir`
- `pc`  out  PC_WIDTH  current program counter
- `fetch_done`  out  1  one-cycle pulse: `ir` holds a new word
- `fetch_err`  out  1  one-cycle pulse: fetch aborted by watchdog
- `busy`  out  1  high while in REQ

## Operation

- States: IDLE, REQ. Reset enters IDLE.
- IDLE: `imem_req`=0, `busy`=0. `fetch_start`=1 -> REQ; watchdog counter cleared.
- REQ: `imem_req`=1, `busy`=1, `imem_addr`=`pc`. Each cycle without ack increments the watchdog counter.
  - `imem_ack`=1: `ir` <= `imem_rdata`; `pc` <= next PC; `fetch_done` pulses; -> IDLE.
  - Counter reaches `TIMEOUT` with no ack: `ir` <= 0 (NOP); `pc` <= next PC; `fetch_err` pulses; -> IDLE.
- Next PC: pending branch target if one is latched, else `pc`+1. Pending flag cleared on use.
- Branch target: `br_sel`=1 -> `br_imm`; `br_sel`=0 -> `pc`+`br_imm`, using the `pc` value at the `br_load` edge. All PC arithmetic is modulo 2^PC_WIDTH (wrap at all-ones -> 0).
- `br_load` in IDLE: `pc` <= target at that edge; no pending flag set.
- `br_load` in REQ: target latched as pending; applied at the completing edge, overriding the increment. A second `br_load` before completion overwrites the pending target.
- `fetch_start` and `br_load` in the same IDLE cycle: `pc` <= target and REQ entered on the same edge; the fetch uses the new target.
- `fetch_start` in REQ is ignored. `imem_ack` in IDLE is ignored.
- Reset (any time, including mid-fetch): `pc`=`RESET_PC`, `ir`=0, pending flag cleared, counter=0, all outputs low except `pc`/`imem_addr`; `imem_req` drops asynchronously.

## Timing

- `fetch_start` sampled at edge k -> `imem_req` high in cycle k+1.
- Ack at edge k+n (n>=1) -> `ir`, `pc` updated and `fetch_done` high in cycle k+n+1; `imem_req` low in the same cycle. Minimum start-to-done latency: 2 edges.
- Back-to-back: `fetch_start` may be asserted in the cycle `fetch_done` is high; REQ re-entered next edge.
- Watchdog: with no ack, `fetch_err` is high in cycle k+TIMEOUT+1.
- `fetch_done` and `fetch_err` are registered, never both high.

## Test plan

- Reset, then three fetches with ack latency 1, memory words 0x11000001/0x11000002/0x11000003 -> `ir` sequence matches, `pc` 0->1->2->3, each `fetch_done` one cycle.
- Ack delayed 4 cycles -> `imem_req` high 4 cycles with `imem_addr` stable, `busy` high throughout, single `fetch_done`.
- In IDLE at `pc`=0x0010, `br_load`, `br_sel`=0, `br_imm`=0xFFFE -> `pc`=0x000E; next fetch addresses 0x000E.
- `br_load` absolute 0x0040 during REQ at `pc`=5 -> after ack `pc`=0x0040 (not 6); `pc`=0xFFFF plain fetch -> `pc`=0x0000.
- No ack, `TIMEOUT`=15 -> `fetch_err` one cycle after 15 REQ cycles, `ir`=0, `pc` incremented, state IDLE.
- `rst_f` low mid-REQ -> `imem_req` low immediately, `pc`=`RESET_PC`, `ir`=0; late ack ignored.
